// File: rtl/mini_core_cr_regfile_if.sv
// Request/response bus between a core and the CR register file.
interface mini_core_cr_regfile_if;
  logic        Req_Valid;
  logic        Req_Wr;
  logic [31:0] Req_Addr;
  logic [31:0] Req_Data;
  logic [3:0]  Req_ByteEn;
  logic        Rsp_Valid;
  logic [31:0] Rsp_Data;
  logic        Rsp_Err;

  modport master (
    output Req_Valid, Req_Wr, Req_Addr, Req_Data, Req_ByteEn,
    input  Rsp_Valid, Rsp_Data, Rsp_Err
  );

  modport slave (
    input  Req_Valid, Req_Wr, Req_Addr, Req_Data, Req_ByteEn,
    output Rsp_Valid, Rsp_Data, Rsp_Err
  );
endinterface

// File: rtl/mini_core_cr_regfile.sv
// Memory-mapped control registers: 7-segment digits, LEDs, buttons with
// sticky edge flags, switches, cursor position and a free-running cycle counter.
module mini_core_cr_regfile #(
  parameter logic [31:0] CR_BASE  = 32'h7000,
  parameter logic [31:0] CR_SIZE  = 32'h1000,
  parameter int unsigned NUM_SEG7 = 6,
  parameter int unsigned LED_W    = 10,
  parameter int unsigned SW_W     = 10,
  parameter int unsigned NUM_BTN  = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_N,
  mini_core_cr_regfile_if.slave   bus,
  input  logic [NUM_BTN-1:0]      Btn_In,
  input  logic [SW_W-1:0]         Sw_In,
  output logic [8*NUM_SEG7-1:0]   Seg7_Out,
  output logic [LED_W-1:0]        Led_Out,
  output logic [31:0]             Cursor_H,
  output logic [31:0]             Cursor_V
);

  localparam int unsigned SEG_W      = 8 * NUM_SEG7;
  localparam logic [32:0] REGION_LO  = 33'(CR_BASE);
  localparam logic [32:0] REGION_HI  = 33'(CR_BASE) + 33'(CR_SIZE);
  localparam logic [29:0] W_LED      = 30'(NUM_SEG7);
  localparam logic [29:0] W_BTN      = 30'(NUM_SEG7 + 1);
  localparam logic [29:0] W_BTN_EVT  = 30'(NUM_SEG7 + 2);
  localparam logic [29:0] W_SWITCH   = 30'(NUM_SEG7 + 3);
  localparam logic [29:0] W_CURSOR_H = 30'(NUM_SEG7 + 4);
  localparam logic [29:0] W_CURSOR_V = 30'(NUM_SEG7 + 5);
  localparam logic [29:0] W_CYCLE    = 30'(NUM_SEG7 + 6);

  logic [SEG_W-1:0]   seg7_q,     seg7_d;
  logic [LED_W-1:0]   led_q,      led_d;
  logic [31:0]        cursor_h_q, cursor_h_d;
  logic [31:0]        cursor_v_q, cursor_v_d;
  logic [31:0]        cycle_q,    cycle_d;
  logic [NUM_BTN-1:0] btn_evt_q,  btn_evt_d;
  logic [NUM_BTN-1:0] btn_s1_q,   btn_s1_d;
  logic [NUM_BTN-1:0] btn_s2_q,   btn_s2_d;
  logic [NUM_BTN-1:0] btn_s3_q,   btn_s3_d;
  logic [SW_W-1:0]    sw_s1_q,    sw_s1_d;
  logic [SW_W-1:0]    sw_s2_q,    sw_s2_d;
  // Counts edges since reset release; edge detection waits until the
  // synchronizer and history flops all hold real samples.
  logic [1:0]         fill_q,     fill_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q,  rsp_data_d;
  logic               rsp_err_q,   rsp_err_d;

  logic [32:0]        addr_ext;
  logic [31:0]        offset;
  logic [29:0]        w;
  logic               hit;
  logic               mapped;
  logic [31:0]        be_mask;
  logic [31:0]        led_wr;
  logic [31:0]        clr_bits;
  logic [31:0]        rdata;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] evt_clr;

  // Address decode and write-data byte masking.
  always_comb begin
    addr_ext = {1'b0, bus.Req_Addr};
    hit      = (addr_ext >= REGION_LO) && (addr_ext < REGION_HI);
    offset   = bus.Req_Addr - CR_BASE;
    w        = 30'(offset >> 2);
    mapped   = (w <= W_CYCLE);
    be_mask  = {{8{bus.Req_ByteEn[3]}}, {8{bus.Req_ByteEn[2]}},
                {8{bus.Req_ByteEn[1]}}, {8{bus.Req_ByteEn[0]}}};
    led_wr   = (32'(led_q) & ~be_mask) | (bus.Req_Data & be_mask);
    clr_bits = bus.Req_Data & be_mask;
  end

  // Read mux: current register contents, zero-extended.
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_SEG7; k++) begin
      if (w == 30'(k)) rdata = {24'd0, seg7_q[8*k +: 8]};
    end
    if (w == W_LED)      rdata = 32'(led_q);
    if (w == W_BTN)      rdata = 32'(btn_s2_q);
    if (w == W_BTN_EVT)  rdata = 32'(btn_evt_q);
    if (w == W_SWITCH)   rdata = 32'(sw_s2_q);
    if (w == W_CURSOR_H) rdata = cursor_h_q;
    if (w == W_CURSOR_V) rdata = cursor_v_q;
    if (w == W_CYCLE)    rdata = cycle_q;
  end

  // Next-state: register writes, responses, synchronizers, events, counter.
  always_comb begin
    seg7_d      = seg7_q;
    led_d       = led_q;
    cursor_h_d  = cursor_h_q;
    cursor_v_d  = cursor_v_q;
    cycle_d     = cycle_q + 32'd1;
    btn_s1_d    = Btn_In;
    btn_s2_d    = btn_s1_q;
    btn_s3_d    = btn_s2_q;
    sw_s1_d     = Sw_In;
    sw_s2_d     = sw_s1_q;
    fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    evt_clr     = '0;

    if (bus.Req_Valid && hit) begin
      if (!bus.Req_Wr) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~mapped;
        rsp_data_d  = mapped ? rdata : 32'd0;
      end else if (!mapped) begin
        rsp_err_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < NUM_SEG7; k++) begin
          if ((w == 30'(k)) && bus.Req_ByteEn[0]) seg7_d[8*k +: 8] = bus.Req_Data[7:0];
        end
        if (w == W_LED)      led_d      = led_wr[LED_W-1:0];
        if (w == W_BTN_EVT)  evt_clr    = clr_bits[NUM_BTN-1:0];
        if (w == W_CURSOR_H) cursor_h_d = (cursor_h_q & ~be_mask) | (bus.Req_Data & be_mask);
        if (w == W_CURSOR_V) cursor_v_d = (cursor_v_q & ~be_mask) | (bus.Req_Data & be_mask);
      end
    end

    // A new rising edge overrides a same-cycle clear.
    btn_rise  = (fill_q == 2'd3) ? (btn_s2_q & ~btn_s3_q) : '0;
    btn_evt_d = (btn_evt_q & ~evt_clr) | btn_rise;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      seg7_q      <= '0;
      led_q       <= '0;
      cursor_h_q  <= '0;
      cursor_v_q  <= '0;
      cycle_q     <= '0;
      btn_evt_q   <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_s3_q    <= '0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      fill_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      seg7_q      <= seg7_d;
      led_q       <= led_d;
      cursor_h_q  <= cursor_h_d;
      cursor_v_q  <= cursor_v_d;
      cycle_q     <= cycle_d;
      btn_evt_q   <= btn_evt_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_s3_q    <= btn_s3_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      fill_q      <= fill_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data  = rsp_data_q;
  assign bus.Rsp_Err   = rsp_err_q;
  assign Seg7_Out      = seg7_q;
  assign Led_Out       = led_q;
  assign Cursor_H      = cursor_h_q;
  assign Cursor_V      = cursor_v_q;

endmodule
